pan_tilt_servo_ctrl: RTL and testbench
======================================

Name: pan_tilt_servo_ctrl

Overview:
- Downstream of the lock-on target controller. Consumes the locked target's screen coordinates and lock status.
- Closes a 50 Hz proportional loop that drives pan/tilt hobby-servo PWM so the locked target moves toward screen centre (320,240).
- Returns the gimbal to home when the lock is released or the target stays lost. Its outputs go straight to the FPGA PMOD servo pins.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; the 1 us tick prescale is CLK_HZ/1_000_000.
- PWM_PERIOD_US, 20000, servo frame length in us; one control update per frame.
- POS_MIN_US, 1000, minimum pulse width.
- POS_MAX_US, 2000, maximum pulse width.
- POS_HOME_US, 1500, home/reset pulse width.
- CENTER_X, 320, screen centre x.
- CENTER_Y, 240, screen centre y.
- DEADBAND, 16, |error| <= DEADBAND gives zero step.
- GAIN_SHIFT, 4, step = error >>> GAIN_SHIFT.
- MAX_STEP, 8, step magnitude clamp in us per update.
- LOST_TIMEOUT, 25, consecutive lost updates before returning home.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- is_locked  in  1  lock-on state from target controller
- target_valid  in  1  locked target currently detected this frame
- target_x  in  10  locked target centre x (0..639)
- target_y  in  10  locked target centre y (0..479)
- center_hit  in  1  target within centre window
- pwm_pan  out  1  pan servo PWM
- pwm_tilt  out  1  tilt servo PWM
- pan_pos  out  12  current pan command in us
- tilt_pos  out  12  current tilt command in us
- state  out  2  0=IDLE 1=TRACK 2=HOLD 3=HOME
- at_limit  out  1  an axis was clamped on the last update

Behaviour:
- Reset (async): pan_pos=tilt_pos=POS_HOME_US, state=IDLE, pwm_pan=pwm_tilt=0, at_limit=0, lost_cnt=0, prescaler=0, us_cnt=0, latched widths=POS_HOME_US.
- Timing: 1 us tick from the prescaler. us_cnt runs 0..PWM_PERIOD_US-1 and wraps.
- upd strobe is the tick with us_cnt==PWM_PERIOD_US-1. State and positions change only on upd.
- PWM: pwm_x = (us_cnt < width_x), registered. width_x loads from x_pos in the clk cycle after upd. A new position therefore appears in the very next frame, and there is no mid-pulse width change.
- Error: ex = target_x - CENTER_X and ey = target_y - CENTER_Y, both signed 11-bit.
- Step per axis:
  - 0 if |e| <= DEADBAND.
  - Otherwise e >>> GAIN_SHIFT (arithmetic, floors). If that result is 0, use ±1 with the sign of e.
  - Then clamp to ±MAX_STEP.
  - Positive ex increases pan_pos; positive ey increases tilt_pos.
- Position = pos + step, saturated to [POS_MIN_US, POS_MAX_US]. at_limit=1 if either axis saturated on this update, else 0. at_limit is cleared on every non-TRACK update.
- FSM, evaluated on upd. !is_locked has priority over all other conditions.
  - IDLE: is_locked && target_valid -> TRACK. Otherwise stay; positions unchanged.
  - TRACK:
    - !is_locked -> HOME.
    - !target_valid -> HOLD with lost_cnt=1; no step applied.
    - Otherwise apply the step and stay.
  - HOLD: positions frozen.
    - !is_locked -> HOME.
    - target_valid -> TRACK with lost_cnt=0; the step is applied on this same update.
    - Otherwise lost_cnt+1; on reaching LOST_TIMEOUT -> HOME with lost_cnt=0.
  - HOME: each axis moves toward POS_HOME_US by min(MAX_STEP, distance).
    - is_locked && target_valid -> TRACK, with the tracking step applied instead of the home step.
    - Both axes at home after the move -> IDLE.
- Inputs are sampled only at upd, so glitches between updates are ignored.
- Reset mid-frame aborts the pulse immediately (pwm=0) and restarts the frame from us_cnt=0.

Optional Feature:
- Macro: CENTER_FREEZE_EN.
- Defined: in TRACK, center_hit=1 at upd forces step=0 on both axes. The state remains TRACK and lost_cnt is unaffected.
- Undefined: center_hit is ignored; only DEADBAND suppresses motion.

Test Plan:
- Reset, then 3 frames with is_locked=0 -> state=IDLE, pan_pos=tilt_pos=1500, pwm high for exactly 1500 us of each 20000 us.
- Lock, valid, target=(400,240) -> TRACK; pan_pos 1500->1505 after the 1st upd and 1510 after the 2nd; tilt stays 1500; the next frame's pulse is 1505 us.
- Target=(600,479) -> steps clamp: pan +8/frame, tilt +8/frame. After 63 updates pan=2000, at_limit=1; target=(330,250) thereafter -> zero step, at_limit=0.
- Target=(300,230) -> ex=-20 gives step -2, ey=-10 is in deadband: pan 1500->1498, tilt unchanged.
- Lock held, target_valid=0 for 25 updates -> HOLD, positions frozen, then HOME. From pan=1520 it reaches 1500 after 3 updates (1512, 1504, 1500), then IDLE.
- With CENTER_FREEZE_EN: target=(400,240) plus center_hit=1 -> pan stays 1500. Without the macro -> pan becomes 1505.

Source files
------------

// File: rtl/pan_tilt_servo_ctrl.sv
// Pan/tilt servo controller: a 50 Hz proportional loop pulls the locked target toward screen centre. State and positions change once per frame; new pulse widths appear in the next frame.
// No backpressure: inputs are sampled only on the frame update. Optional CENTER_FREEZE_EN lets center_hit suppress tracking steps.
module pan_tilt_servo_ctrl #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int PWM_PERIOD_US = 20000,
  parameter int POS_MIN_US    = 1000,
  parameter int POS_MAX_US    = 2000,
  parameter int POS_HOME_US   = 1500,
  parameter int CENTER_X      = 320,
  parameter int CENTER_Y      = 240,
  parameter int DEADBAND      = 16,
  parameter int GAIN_SHIFT    = 4,
  parameter int MAX_STEP      = 8,
  parameter int LOST_TIMEOUT  = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_locked,
  input  logic        target_valid,
  input  logic [9:0]  target_x,
  input  logic [9:0]  target_y,
  input  logic        center_hit,
  output logic        pwm_pan,
  output logic        pwm_tilt,
  output logic [11:0] pan_pos,
  output logic [11:0] tilt_pos,
  output logic [1:0]  state,
  output logic        at_limit
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_HOLD = 2'd2, S_HOME = 2'd3} state_t;

  localparam int PRE   = CLK_HZ / 1_000_000;
  localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int US_W  = $clog2(PWM_PERIOD_US);
  localparam int LC_W  = $clog2(LOST_TIMEOUT + 1);
  localparam logic signed [10:0] DB     = 11'(DEADBAND);
  localparam logic signed [10:0] MS     = 11'(MAX_STEP);
  localparam logic signed [13:0] P_MIN  = 14'(POS_MIN_US);
  localparam logic signed [13:0] P_MAX  = 14'(POS_MAX_US);
  localparam logic [11:0]        P_HOME = 12'(POS_HOME_US);
  localparam logic [11:0]        STEP_U = 12'(MAX_STEP);

  state_t            st, nxt_st;
  logic [PRE_W-1:0]  prescaler;
  logic [US_W-1:0]   us_cnt;
  logic [LC_W-1:0]   lost_cnt, nxt_lost;
  logic [11:0]       width_pan, width_tilt, nxt_pan, nxt_tilt;
  logic              tick, upd, upd_d, nxt_lim, do_track, freeze;
  logic signed [10:0] ex, ey;
  logic signed [11:0] stp_pan, stp_tilt;
  logic [12:0]       trk_pan, trk_tilt;

  // Proportional step: deadband, floor-shift, minimum magnitude of one, then clamp.
  function automatic logic signed [11:0] axis_step(input logic signed [10:0] e);
    logic signed [10:0] mag, s;
    mag = (e < 0) ? -e : e;
    s   = e >>> GAIN_SHIFT;
    if (mag <= DB) begin
      axis_step = '0;
    end else begin
      if (s == 0) s = (e < 0) ? -11'sd1 : 11'sd1;
      if (s > MS) s = MS;
      else if (s < -MS) s = -MS;
      axis_step = 12'(s);
    end
  endfunction

  // Returns {saturated, new position}.
  function automatic logic [12:0] track_axis(input logic [11:0] pos, input logic signed [11:0] stp);
    logic signed [13:0] sum;
    sum = $signed({2'b00, pos}) + 14'(stp);
    if (sum > P_MAX)      track_axis = {1'b1, P_MAX[11:0]};
    else if (sum < P_MIN) track_axis = {1'b1, P_MIN[11:0]};
    else                  track_axis = {1'b0, sum[11:0]};
  endfunction

  function automatic logic [11:0] home_move(input logic [11:0] pos);
    logic [11:0] d;
    if (pos > P_HOME) begin
      d = pos - P_HOME;
      home_move = pos - ((d > STEP_U) ? STEP_U : d);
    end else begin
      d = P_HOME - pos;
      home_move = pos + ((d > STEP_U) ? STEP_U : d);
    end
  endfunction

`ifdef CENTER_FREEZE_EN
  assign freeze = center_hit;
`else
  logic unused_center_hit;
  assign unused_center_hit = center_hit;
  assign freeze = 1'b0;
`endif

  assign tick     = (prescaler == PRE_W'(PRE - 1));
  assign upd      = tick && (us_cnt == US_W'(PWM_PERIOD_US - 1));
  assign ex       = 11'($signed({1'b0, target_x}) - CENTER_X);
  assign ey       = 11'($signed({1'b0, target_y}) - CENTER_Y);
  assign stp_pan  = freeze ? 12'sd0 : axis_step(ex);
  assign stp_tilt = freeze ? 12'sd0 : axis_step(ey);
  assign trk_pan  = track_axis(pan_pos, stp_pan);
  assign trk_tilt = track_axis(tilt_pos, stp_tilt);
  assign state    = st;

  // Next-state decision for the frame update; lock loss always wins.
  always_comb begin
    nxt_st   = st;
    nxt_pan  = pan_pos;
    nxt_tilt = tilt_pos;
    nxt_lim  = 1'b0;
    nxt_lost = lost_cnt;
    do_track = 1'b0;
    case (st)
      S_IDLE: begin
        if (is_locked && target_valid) begin
          nxt_st   = S_TRACK;
          do_track = 1'b1;
        end
      end
      S_TRACK: begin
        if (!is_locked) begin
          nxt_st = S_HOME;
        end else if (!target_valid) begin
          nxt_st   = S_HOLD;
          nxt_lost = LC_W'(1);
        end else begin
          do_track = 1'b1;
        end
      end
      S_HOLD: begin
        if (!is_locked) begin
          nxt_st   = S_HOME;
          nxt_lost = '0;
        end else if (target_valid) begin
          nxt_st   = S_TRACK;
          nxt_lost = '0;
          do_track = 1'b1;
        end else if (lost_cnt + 1'b1 == LC_W'(LOST_TIMEOUT)) begin
          nxt_st   = S_HOME;
          nxt_lost = '0;
        end else begin
          nxt_lost = lost_cnt + 1'b1;
        end
      end
      default: begin
        if (is_locked && target_valid) begin
          nxt_st   = S_TRACK;
          do_track = 1'b1;
        end else begin
          nxt_pan  = home_move(pan_pos);
          nxt_tilt = home_move(tilt_pos);
          if (nxt_pan == P_HOME && nxt_tilt == P_HOME) nxt_st = S_IDLE;
        end
      end
    endcase
    if (do_track) begin
      nxt_pan  = trk_pan[11:0];
      nxt_tilt = trk_tilt[11:0];
      nxt_lim  = trk_pan[12] | trk_tilt[12];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler  <= '0;
      us_cnt     <= '0;
      upd_d      <= 1'b0;
      width_pan  <= P_HOME;
      width_tilt <= P_HOME;
      pwm_pan    <= 1'b0;
      pwm_tilt   <= 1'b0;
      st         <= S_IDLE;
      pan_pos    <= P_HOME;
      tilt_pos   <= P_HOME;
      lost_cnt   <= '0;
      at_limit   <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) us_cnt <= upd ? '0 : us_cnt + 1'b1;
      upd_d <= upd;
      // Widths latch just after the update so a pulse never changes mid-flight.
      if (upd_d) begin
        width_pan  <= pan_pos;
        width_tilt <= tilt_pos;
      end
      pwm_pan  <= (16'(us_cnt) < 16'(width_pan));
      pwm_tilt <= (16'(us_cnt) < 16'(width_tilt));
      if (upd) begin
        st       <= nxt_st;
        pan_pos  <= nxt_pan;
        tilt_pos <= nxt_tilt;
        lost_cnt <= nxt_lost;
        at_limit <= nxt_lim;
      end
    end
  end

endmodule

// File: tb/tb_pan_tilt_servo_ctrl.sv
// Scoreboard bench for pan_tilt_servo_ctrl with a scaled-down frame (1 us per clock, 400 us frame, 200..300 us travel).
module tb_pan_tilt_servo_ctrl;
  localparam int CLK_HZ = 1_000_000;
  localparam int PERIOD = 400;
  localparam int PMIN   = 200;
  localparam int PMAX   = 300;
  localparam int HOME   = 250;
  localparam int TMO    = 4;
`ifdef CENTER_FREEZE_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic is_locked = 1'b0, target_valid = 1'b0, center_hit = 1'b0;
  logic [9:0] target_x = 10'd320, target_y = 10'd240;
  logic pwm_pan, pwm_tilt, at_limit;
  logic [11:0] pan_pos, tilt_pos;
  logic [1:0] state;

  typedef struct {int st; int pan; int tilt; int lim;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  bit mon_en = 1'b1;
  int ep = HOME, et = HOME, est = 0, el = 0;

  pan_tilt_servo_ctrl #(
    .CLK_HZ(CLK_HZ), .PWM_PERIOD_US(PERIOD), .POS_MIN_US(PMIN), .POS_MAX_US(PMAX),
    .POS_HOME_US(HOME), .LOST_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .is_locked(is_locked), .target_valid(target_valid),
    .target_x(target_x), .target_y(target_y), .center_hit(center_hit),
    .pwm_pan(pwm_pan), .pwm_tilt(pwm_tilt), .pan_pos(pan_pos), .tilt_pos(tilt_pos),
    .state(state), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  task automatic wait_rise(output bit ok);
    int n = 0;
    while (pwm_pan && n < 2 * PERIOD) begin @(negedge clk); n++; end
    while (!pwm_pan && n < 2 * PERIOD) begin @(negedge clk); n++; end
    ok = pwm_pan && (n < 2 * PERIOD);
  endtask

  task automatic push();
    exp_t e;
    e.st = est; e.pan = ep; e.tilt = et; e.lim = el;
    sb.push_back(e);
  endtask

  // Drive inputs right after a frame starts; the update at the end of this frame samples them.
  task automatic step(input bit lk, input bit vl, input int x, input int y, input bit ch);
    bit ok;
    wait_rise(ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL frame_sync: no pwm_pan rising edge within %0d cycles", 2 * PERIOD);
    end
    is_locked = lk; target_valid = vl; center_hit = ch;
    target_x = 10'(x); target_y = 10'(y);
  endtask

  function automatic int toward_home(input int p);
    if (p > HOME) return (p - HOME > 8) ? p - 8 : HOME;
    if (p < HOME) return (HOME - p > 8) ? p + 8 : HOME;
    return p;
  endfunction

  task automatic monitor();
    bit ok;
    exp_t e;
    int cp, ct, frame = 0;
    forever begin
      wait_rise(ok);
      if (!mon_en) break;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL mon_frame: no frame start seen, got none required one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: frame %0d got output but required no pending expectation", frame);
      end else begin
        e = sb.pop_front();
        if (int'(state) != e.st || int'(pan_pos) != e.pan || int'(tilt_pos) != e.tilt || int'(at_limit) != e.lim) begin
          errors++;
          $display("FAIL upd frame %0d: got st=%0d pan=%0d tilt=%0d lim=%0d required st=%0d pan=%0d tilt=%0d lim=%0d",
                   frame, state, pan_pos, tilt_pos, at_limit, e.st, e.pan, e.tilt, e.lim);
        end
        cp = 0; ct = 0;
        for (int i = 0; i < PERIOD - 5; i++) begin
          if (pwm_pan) cp++;
          if (pwm_tilt) ct++;
          @(negedge clk);
        end
        checks++;
        if (cp != e.pan) begin
          errors++;
          $display("FAIL pulse_pan frame %0d: got %0d us required %0d us", frame, cp, e.pan);
        end
        checks++;
        if (ct != e.tilt) begin
          errors++;
          $display("FAIL pulse_tilt frame %0d: got %0d us required %0d us", frame, ct, e.tilt);
        end
      end
      frame++;
    end
  endtask

  initial begin
    bit ok;
    int cnt;
    push();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    fork monitor(); join_none

    repeat (3) begin step(0, 0, 320, 240, 0); push(); end
    step(1, 1, 400, 240, 0); est = 1; ep = 255; push();
    step(1, 1, 400, 240, 0); ep = 260; push();
    step(1, 1, 400, 240, 1); if (!FREEZE) ep = 265; push();
    step(1, 1, 300, 230, 0); ep -= 2; push();
    step(1, 1, 330, 250, 0); push();
    step(1, 1, 337, 240, 0); ep += 1; push();
    step(1, 1, 336, 240, 0); push();
    step(1, 1, 303, 240, 0); ep -= 2; push();
    repeat (8) begin
      step(1, 1, 600, 479, 0);
      el = 0; ep += 8; et += 8;
      if (ep > PMAX) begin ep = PMAX; el = 1; end
      if (et > PMAX) begin et = PMAX; el = 1; end
      push();
    end
    step(1, 1, 330, 250, 0); el = 0; push();
    repeat (3) begin step(1, 1, 0, 240, 0); ep -= 8; push(); end
    step(1, 1, 224, 240, 0); ep -= 6; push();
    step(1, 0, 0, 0, 0); est = 2; push();
    step(1, 1, 400, 240, 0); est = 1; ep += 5; push();
    step(0, 1, 400, 240, 0); est = 3; push();
    step(1, 1, 400, 240, 0); est = 1; ep += 5; push();
    repeat (TMO - 1) begin step(1, 0, 0, 0, 0); est = 2; push(); end
    step(1, 0, 0, 0, 0); est = 3; push();
    while (!(ep == HOME && et == HOME)) begin
      step(1, 0, 0, 0, 0);
      ep = toward_home(ep); et = toward_home(et);
      est = (ep == HOME && et == HOME) ? 0 : 3;
      push();
    end
    step(1, 0, 0, 0, 0); push();
    step(1, 1, 400, 240, 0); est = 1; ep += 5; push();

    wait_rise(ok);
    repeat (PERIOD - 2) @(negedge clk);
    mon_en = 1'b0;
    wait_rise(ok);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (pwm_pan !== 1'b0 || pwm_tilt !== 1'b0) begin
      errors++;
      $display("FAIL rst_pwm: got pan=%b tilt=%b required 0 0", pwm_pan, pwm_tilt);
    end
    checks++;
    if (state !== 2'd0 || pan_pos !== 12'(HOME) || tilt_pos !== 12'(HOME) || at_limit !== 1'b0) begin
      errors++;
      $display("FAIL rst_state: got st=%0d pan=%0d tilt=%0d lim=%0d required 0 %0d %0d 0",
               state, pan_pos, tilt_pos, at_limit, HOME, HOME);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_pan !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart: got pwm_pan=%b required 1", pwm_pan);
    end
    cnt = 0;
    while (pwm_pan && cnt < PERIOD) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt != HOME) begin
      errors++;
      $display("FAIL rst_pulse: got %0d us required %0d us", cnt, HOME);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
